gain_clip_pipe: RTL and testbench

//  Multi-channel, pipelined gain-and-clip stage for video sample paths.
//  - Per channel: multiplies each DW-bit sample by a GW-bit gain.
//  - Clips each product to the legal [FLOOR, CEILING] range.
//  - Uses valid/ready on both sides, so it can sit between pixel producer and consumer under backpressure.
//  - Provides clip-event statistics for headroom monitoring.

---
 rtl/gain_clip_pipe_pkg.sv | 24 ++
 rtl/gain_clip_pipe_if.sv | 24 ++
 rtl/gain_clip_pipe_lane.sv | 47 ++++
 rtl/gain_clip_pipe.sv | 111 +++++++++++
 tb/tb_gain_clip_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gain_clip_pipe_pkg.sv
// Shared constants, clip-event type and clip helper for the gain_clip_pipe datapath.
package gain_clip_pkg;

  localparam int DEF_FLOOR   = 16;
  localparam int DEF_CEILING = 235;

  typedef struct packed {
    logic hi;
    logic lo;
  } clip_evt_t;

  // Compares at full product width so large products never alias into range.
  function automatic logic [31:0] clip_val(input logic [31:0] p,
                                           input logic [31:0] floor_v,
                                           input logic [31:0] ceil_v);
    if (p > ceil_v)
      return ceil_v;
    else if (p < floor_v)
      return floor_v;
    else
      return p;
  endfunction

endpackage

// File: rtl/gain_clip_pipe_if.sv
// Valid/ready stream bundle for the gain_clip_pipe input and output sides.
interface gain_clip_pipe_if #(
  parameter int NCH = 3,
  parameter int DW  = 8,
  parameter int GW  = 4
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [NCH*DW-1:0] IN_DATA;
  logic [NCH*GW-1:0] GAIN;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [NCH*DW-1:0] OUT_DATA;

  modport master (
    output IN_VALID, IN_DATA, GAIN, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA
  );

  modport slave (
    input  IN_VALID, IN_DATA, GAIN, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/gain_clip_pipe_lane.sv
// One channel of gain_clip_pipe: S1 holds the raw product, S2 the clipped sample.
module gain_clip_lane
  import gain_clip_pkg::*;
#(
  parameter int DW      = 8,
  parameter int GW      = 4,
  parameter int FLOOR   = DEF_FLOOR,
  parameter int CEILING = DEF_CEILING
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_s1,
  input  logic          ld_s2,
  input  logic [DW-1:0] data,
  input  logic [GW-1:0] gain,
  output logic [DW-1:0] q,
  output clip_evt_t     evt
);

  localparam int PW = DW + GW;

  logic [PW-1:0] prod_q;
  logic [31:0]   prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prod_q <= '0;
    else if (ld_s1)
      prod_q <= PW'(data) * PW'(gain);
  end

  assign prod_ext = 32'(prod_q);

  // Events describe the beat sitting in S1; the top counts them as it moves on.
  always_comb begin
    evt.hi = prod_ext > 32'(CEILING);
    evt.lo = prod_ext < 32'(FLOOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (ld_s2)
      q <= DW'(clip_val(prod_ext, 32'(FLOOR), 32'(CEILING)));
  end

endmodule

// File: rtl/gain_clip_pipe.sv
// Two-stage multi-channel gain-and-clip pipeline with valid/ready on both sides.
// Clip statistics counters are built only when GAIN_CLIP_STATS_EN is defined.
module gain_clip_pipe
  import gain_clip_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int DW      = 8,
  parameter int GW      = 4,
  parameter int FLOOR   = DEF_FLOOR,
  parameter int CEILING = DEF_CEILING,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  gain_clip_pipe_if.slave  bus,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] CLIP_HI_CNT,
  output logic [CNT_W-1:0] CLIP_LO_CNT
);

  if (!(FLOOR <= CEILING && longint'(CEILING) < (longint'(1) << DW) &&
        NCH >= 1 && CNT_W >= 1 && DW + GW <= 32))
    $fatal(1, "gain_clip_pipe: illegal parameter combination");

  logic s1_v, s2_v;
  logic s1_adv, s2_adv;
  logic ld_s1, ld_s2;
  logic [NCH*DW-1:0] out_data;
  clip_evt_t [NCH-1:0] evt;

  assign s2_adv = !s2_v || bus.OUT_READY;
  assign s1_adv = !s1_v || s2_adv;
  assign ld_s1  = bus.IN_VALID && s1_adv;
  assign ld_s2  = s1_v && s2_adv;

  assign bus.IN_READY  = s1_adv;
  assign bus.OUT_VALID = s2_v;
  assign bus.OUT_DATA  = out_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_adv)
        s1_v <= bus.IN_VALID;
      if (s2_adv)
        s2_v <= s1_v;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    gain_clip_lane #(
      .DW      (DW),
      .GW      (GW),
      .FLOOR   (FLOOR),
      .CEILING (CEILING)
    ) u_lane (
      .clk   (CLK),
      .rst_n (RST_N),
      .ld_s1 (ld_s1),
      .ld_s2 (ld_s2),
      .data  (bus.IN_DATA[k*DW +: DW]),
      .gain  (bus.GAIN[k*GW +: GW]),
      .q     (out_data[k*DW +: DW]),
      .evt   (evt[k])
    );
  end

`ifdef GAIN_CLIP_STATS_EN
  // Extra headroom bits so the per-beat sum can be compared before saturating.
  localparam int SW = CNT_W + $clog2(NCH + 1) + 1;
  localparam logic [SW-1:0] CNT_MAX = (SW'(1) << CNT_W) - SW'(1);

  logic [SW-1:0]    n_hi, n_lo, sum_hi, sum_lo;
  logic [CNT_W-1:0] hi_q, lo_q;

  always_comb begin
    n_hi = '0;
    n_lo = '0;
    for (int k = 0; k < NCH; k++) begin
      n_hi = n_hi + SW'(evt[k].hi);
      n_lo = n_lo + SW'(evt[k].lo);
    end
    sum_hi = SW'(hi_q) + n_hi;
    sum_lo = SW'(lo_q) + n_lo;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (CNT_CLR) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (ld_s2) begin
      hi_q <= (sum_hi > CNT_MAX) ? CNT_W'(CNT_MAX) : sum_hi[CNT_W-1:0];
      lo_q <= (sum_lo > CNT_MAX) ? CNT_W'(CNT_MAX) : sum_lo[CNT_W-1:0];
    end
  end

  assign CLIP_HI_CNT = hi_q;
  assign CLIP_LO_CNT = lo_q;
`else
  logic stats_unused;
  assign stats_unused = ^{CNT_CLR, evt};
  assign CLIP_HI_CNT  = '0;
  assign CLIP_LO_CNT  = '0;
`endif

endmodule

// File: tb/tb_gain_clip_pipe.sv
// Scoreboard bench for gain_clip_pipe: directed cases, backpressure, reset and random stress.
module tb_gain_clip_pipe;

  localparam int NCH = 3, DW = 8, GW = 4, CNT_W = 16;
  localparam int CNT_SAT = 65535;

  logic CLK = 1'b0;
  logic RST_N;
  logic CNT_CLR;
  logic [CNT_W-1:0] hi_cnt, lo_cnt;

  gain_clip_pipe_if #(.NCH(NCH), .DW(DW), .GW(GW)) bus ();

  gain_clip_pipe #(
    .NCH(NCH), .DW(DW), .GW(GW), .FLOOR(16), .CEILING(235), .CNT_W(CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .CNT_CLR     (CNT_CLR),
    .CLIP_HI_CNT (hi_cnt),
    .CLIP_LO_CNT (lo_cnt)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  int exp_hi = 0;
  int exp_lo = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each channel is clip(d*g) into [16,235] using plain integer math.
  function automatic void model(input logic [23:0] d, input logic [11:0] g,
                                output logic [23:0] o, output int nh, output int nl);
    o = '0; nh = 0; nl = 0;
    for (int c = 0; c < NCH; c++) begin
      int p, r;
      p = int'(d[c*8 +: 8]) * int'(g[c*4 +: 4]);
      if (p > 235) begin r = 235; nh++; end
      else if (p < 16) begin r = 16; nl++; end
      else r = p;
      o[c*8 +: 8] = 8'(r);
    end
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > CNT_SAT) ? CNT_SAT : a + b;
  endfunction

  logic prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("hold_data", 32'(bus.OUT_DATA), 32'(prev_data));
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        logic [23:0] o;
        int nh, nl;
        model(bus.IN_DATA, bus.GAIN, o, nh, nl);
        exp_q.push_back(o);
        exp_hi = sat_add(exp_hi, nh);
        exp_lo = sat_add(exp_lo, nl);
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %0d expected no beat", bus.OUT_DATA);
        end else begin
          chk("out_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
      prev_data  = bus.OUT_DATA;
    end
  end

  task automatic send(input logic [23:0] d, input logic [11:0] g);
    bit ok = 1'b0;
    bus.IN_VALID = 1'b1; bus.IN_DATA = d; bus.GAIN = g;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK); ok = bus.IN_READY;
      @(posedge CLK); #1;
    end
    bus.IN_VALID = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef GAIN_CLIP_STATS_EN
    chk({tag, "_hi"}, 32'(hi_cnt), 32'(exp_hi));
    chk({tag, "_lo"}, 32'(lo_cnt), 32'(exp_lo));
`else
    chk({tag, "_hi_tied"}, 32'(hi_cnt), 32'd0);
    chk({tag, "_lo_tied"}, 32'(lo_cnt), 32'd0);
`endif
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc;
    RST_N = 1'b0; CNT_CLR = 1'b0;
    bus.IN_VALID = 1'b0; bus.IN_DATA = '0; bus.GAIN = '0; bus.OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_out_data", 32'(bus.OUT_DATA), 32'd0);
    chk("rst_hi", 32'(hi_cnt), 32'd0);
    chk("rst_lo", 32'(lo_cnt), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Basic in-range beat and two-cycle latency
    bus.IN_VALID = 1'b1; bus.IN_DATA = {8'd20, 8'd50, 8'd100}; bus.GAIN = {4'd1, 4'd3, 4'd2};
    @(negedge CLK);
    chk("lat_in_ready", 32'(bus.IN_READY), 32'd1);
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    chk("lat_cycle1", 32'(bus.OUT_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("lat_cycle2", 32'(bus.OUT_VALID), 32'd1);
    chk("lat_data", 32'(bus.OUT_DATA), 32'({8'd20, 8'd150, 8'd200}));
    drain();
    check_cnt("basic");

    // Clip high, clip low and zero gain
    send({8'd0, 8'd3, 8'd200}, {4'd0, 4'd1, 4'd15});
    drain();
`ifdef GAIN_CLIP_STATS_EN
    chk("clip_hi_is_1", 32'(hi_cnt), 32'd1);
    chk("clip_lo_is_2", 32'(lo_cnt), 32'd2);
`endif
    check_cnt("clip");

    // Values right at and just past each bound
    send({8'd236, 8'd235, 8'd16}, {4'd1, 4'd1, 4'd1});
    send({8'd15, 8'd17, 8'd0}, {4'd1, 4'd1, 4'd15});
    send({8'd117, 8'd118, 8'd8}, {4'd2, 4'd2, 4'd2});
    send({8'd255, 8'd1, 8'd16}, {4'd15, 4'd15, 4'd1});
    drain();
    check_cnt("bound");

    // Backpressure: only two beats fit while the output is stalled
    bus.OUT_READY = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.IN_VALID = 1'b1; bus.IN_DATA = 24'($urandom); bus.GAIN = 12'($urandom);
      @(negedge CLK);
      if (bus.IN_READY) acc++;
      @(posedge CLK); #1;
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(bus.IN_READY), 32'd0);
    drain();
    check_cnt("bp");

`ifdef GAIN_CLIP_STATS_EN
    // Saturation: 22000 beats x 3 high clips exceeds 65535
    CNT_CLR = 1'b1;
    @(posedge CLK); #1;
    CNT_CLR = 1'b0; exp_hi = 0; exp_lo = 0;
    check_cnt("clr");
    bus.IN_VALID = 1'b1; bus.IN_DATA = {3{8'd255}}; bus.GAIN = {3{4'd15}};
    repeat (22000) begin
      @(posedge CLK); #1;
    end
    drain();
    chk("sat_hi", 32'(hi_cnt), 32'd65535);
    check_cnt("sat");
`endif

    // Clear coincident with a beat moving S1->S2
    bus.IN_VALID = 1'b1; bus.IN_DATA = {8'd0, 8'd200, 8'd200}; bus.GAIN = {4'd0, 4'd15, 4'd15};
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0; CNT_CLR = 1'b1;
    @(posedge CLK); #1;
    CNT_CLR = 1'b0; exp_hi = 0; exp_lo = 0;
    chk("clr_wins_hi", 32'(hi_cnt), 32'd0);
    chk("clr_wins_lo", 32'(lo_cnt), 32'd0);
    drain();
    check_cnt("post_clr");

    // Reset with both stages full
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.IN_VALID = 1'b1; bus.IN_DATA = {8'd90, 8'd3, 8'd180}; bus.GAIN = {4'd2, 4'd1, 4'd4};
      @(posedge CLK); #1;
    end
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("mid_rst_out_data", 32'(bus.OUT_DATA), 32'd0);
    chk("mid_rst_hi", 32'(hi_cnt), 32'd0);
    chk("mid_rst_lo", 32'(lo_cnt), 32'd0);
    exp_q.delete(); exp_hi = 0; exp_lo = 0;
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    send({8'd60, 8'd7, 8'd250}, {4'd3, 4'd2, 4'd1});
    drain();
    check_cnt("post_rst");

    // Random traffic on both sides
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      bus.IN_VALID  = ($urandom_range(0, 3) != 0);
      bus.IN_DATA   = 24'($urandom);
      bus.GAIN      = ($urandom_range(0, 7) == 0) ? 12'h111 : 12'($urandom);
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (bus.IN_VALID && bus.IN_READY) acc++;
      @(posedge CLK); #1;
      cyc++;
    end
    chk("rand_beats", 32'(acc), 32'd10000);
    drain();
    check_cnt("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
